// File: rtl/add_sub_int_serial.sv
// add_sub_int_serial
//   Digit-serial integer adder/subtractor. Each BUSY cycle adds DIGIT bits of
//   A and B' (B, or ~B for subtract) with a registered carry, LSB digit first,
//   so one operation takes WIDTH/DIGIT BUSY cycles and then waits in DONE for
//   the consumer. Subtraction is A + ~B + 1, with the +1 preloaded as the
//   initial carry.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands and op_sub are valid
//   in_ready   block can accept an operation (IDLE, or DONE with out_ready)
//   op_sub     0 = a+b, 1 = a-b
//   a, b       WIDTH-bit operands
//   out_valid  result and flags valid (held until out_ready)
//   out_ready  consumer accepts the result
//   result     (a +/- b) mod 2^WIDTH
//   carry_out  carry out of the MSB (for subtract, 1 = no borrow)
//   overflow   signed overflow
module add_sub_int_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_err
    $error("add_sub_int_serial: DIGIT must be in 1..WIDTH and divide WIDTH");
  end

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic               accept;
  logic               last;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               carry_r;
  logic [CNT_W-1:0]   cnt;
  logic [DIGIT-1:0]   a_dig;
  logic [DIGIT-1:0]   b_dig;
  logic [DIGIT:0]     dsum;

  // One digit of ripple addition; the top bit is the digit carry-out.
  function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] x,
                                               input logic [DIGIT-1:0] y,
                                               input logic             cin);
    return {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
  endfunction

  // Signed overflow from the operand MSBs and the sum MSB: equivalent to
  // carry-into-MSB XOR carry-out-of-MSB, and valid for DIGIT = 1 as well.
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  assign a_dig = a_r[cnt*DIGIT +: DIGIT];
  assign b_dig = b_r[cnt*DIGIT +: DIGIT];
  assign dsum  = digit_add(a_dig, b_dig, carry_r);
  assign last  = (cnt == CNT_W'(N - 1));

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      BUSY: if (last) state_nxt = DONE;
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    accept = in_valid && in_ready;
    if (accept) state_nxt = BUSY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt == DONE);
    end
  end

  // Operand capture on accept, then one digit per BUSY edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r       <= '0;
      b_r       <= '0;
      carry_r   <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      a_r     <= a;
      b_r     <= op_sub ? ~b : b;
      carry_r <= op_sub;
      cnt     <= '0;
    end else if (state == BUSY) begin
      result[cnt*DIGIT +: DIGIT] <= dsum[DIGIT-1:0];
      carry_r                    <= dsum[DIGIT];
      cnt                        <= last ? '0 : cnt + CNT_W'(1);
      if (last) begin
        carry_out <= dsum[DIGIT];
        overflow  <= signed_ovf(a_r[WIDTH-1], b_r[WIDTH-1], dsum[DIGIT-1]);
      end
    end
  end

endmodule
